// File: rtl/dmux_rr_dispatcher.sv
// Round-robin feeder for a 1:4 DMUX: 2-entry input FIFO, held output register, sticky stall flag.
// Optional build macro DMUX_RR_SKIP_EN: at load, skip ahead to the first ready channel from rr_ptr.
module dmux_rr_dispatcher #(
  parameter int WIDTH       = 8,
  parameter int STALL_LIMIT = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       CH_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [1:0]       S,
  output logic             OUT_VALID,
  output logic [3:0]       Y_VALID,
  output logic [15:0]      TX_COUNT,
  output logic             STALL_ERR
);

  localparam int SCW = $clog2(STALL_LIMIT + 1);

  typedef enum logic {IDLE, HOLD} out_state_t;

  out_state_t       state;
  logic [WIDTH-1:0] fifo_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       fifo_cnt;
  logic [1:0]       rr_ptr;
  logic [SCW-1:0]   stall_cnt;
  logic             push;
  logic             transfer;
  logic             load;
  logic [1:0]       base_ptr;
  logic [1:0]       next_sel;

  assign IN_READY  = (fifo_cnt != 2'd2);
  assign push      = IN_VALID && IN_READY;
  assign OUT_VALID = (state == HOLD);
  assign transfer  = OUT_VALID && CH_READY[S];
  assign load      = (!OUT_VALID || transfer) && (fifo_cnt != 2'd0);
  assign Y_VALID   = OUT_VALID ? (4'b0001 << S) : 4'b0000;

  // A word loaded in the same cycle as a transfer must already see the advanced pointer.
  assign base_ptr  = transfer ? (S + 2'd1) : rr_ptr;

`ifdef DMUX_RR_SKIP_EN
  always_comb begin
    next_sel = base_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (CH_READY[base_ptr + 2'(i)]) next_sel = base_ptr + 2'(i);
    end
  end
`else
  assign next_sel = base_ptr;
`endif

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= IN_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
      rr_ptr    <= 2'd0;
      OUT_DATA  <= '0;
      S         <= 2'd0;
      TX_COUNT  <= 16'd0;
      stall_cnt <= '0;
      STALL_ERR <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (load) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, load};

      if (transfer) begin
        rr_ptr   <= S + 2'd1;
        TX_COUNT <= TX_COUNT + 16'd1;
      end

      if (load) begin
        OUT_DATA <= fifo_mem[rd_ptr];
        S        <= next_sel;
        state    <= HOLD;
      end else if (transfer) begin
        state    <= IDLE;
      end

      // Counter saturates at the limit; the flag stays set until reset.
      if (!OUT_VALID || transfer) begin
        stall_cnt <= '0;
      end else begin
        if (stall_cnt < SCW'(STALL_LIMIT)) stall_cnt <= stall_cnt + SCW'(1);
        if (stall_cnt >= SCW'(STALL_LIMIT - 1)) STALL_ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmux_rr_dispatcher.sv
// Self-checking bench for dmux_rr_dispatcher: directed scenarios plus randomized traffic
// checked against a word-queue scoreboard. Honours DMUX_RR_SKIP_EN when defined.
module tb_dmux_rr_dispatcher;

  localparam int LIM = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [3:0] CH_READY = 4'h0;
  logic [7:0] OUT_DATA;
  logic [1:0] S;
  logic       OUT_VALID;
  logic [3:0] Y_VALID;
  logic [15:0] TX_COUNT;
  logic       STALL_ERR;

  dmux_rr_dispatcher #(.WIDTH(8), .STALL_LIMIT(LIM)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .CH_READY(CH_READY), .OUT_DATA(OUT_DATA), .S(S), .OUT_VALID(OUT_VALID),
    .Y_VALID(Y_VALID), .TX_COUNT(TX_COUNT), .STALL_ERR(STALL_ERR)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every accepted, not yet delivered word with the edge it was accepted on.
  typedef struct {logic [7:0] d; int t;} word_t;
  word_t      q[$];
  int         n = 0;
  int         exp_rr = 0;
  int         exp_tx = 0;
  int         stall_run = 0;
  bit         exp_err = 1'b0;
  bit         head_seen = 1'b0;
  logic [1:0] exp_s = 2'd0;
  logic [3:0] last_cr = 4'h0;
  int         total = 0;
  int         bad = 0;

  function automatic logic [1:0] pick(input int rr, input logic [3:0] cr);
`ifdef DMUX_RR_SKIP_EN
    for (int i = 0; i < 4; i++) if (cr[(rr + i) % 4]) return 2'((rr + i) % 4);
`endif
    return 2'(rr);
  endfunction

  // Head word is on the output once it was accepted before the latest edge.
  function automatic bit exp_ov();
    return (q.size() > 0) && (q[0].t < n);
  endfunction

  function automatic bit exp_in_ready();
    return (q.size() - (exp_ov() ? 1 : 0)) < 2;
  endfunction

  function automatic logic [3:0] exp_y();
    return exp_ov() ? (4'b0001 << exp_s) : 4'b0000;
  endfunction

  task automatic cycle(input logic v, input logic [7:0] d, input logic [3:0] cr);
    bit    ov_pre, xfer, pu;
    word_t w;
    IN_VALID = v;
    IN_DATA  = d;
    CH_READY = cr;
    ov_pre   = exp_ov();
    xfer     = ov_pre && cr[exp_s];
    pu       = v && exp_in_ready();
    @(posedge CLK);
    n++;
    #1;
    if (RST) begin
      q.delete();
      exp_rr = 0; exp_tx = 0; stall_run = 0; exp_err = 1'b0; head_seen = 1'b0;
    end else begin
      if (xfer) begin
        void'(q.pop_front());
        exp_rr    = (int'(exp_s) + 1) % 4;
        exp_tx    = (exp_tx + 1) % 65536;
        stall_run = 0;
        head_seen = 1'b0;
      end else if (ov_pre) begin
        stall_run++;
        if (stall_run >= LIM) exp_err = 1'b1;
      end
      if (pu) begin
        w.d = d;
        w.t = n;
        q.push_back(w);
      end
    end
    last_cr = cr;
    if (exp_ov() && !head_seen) begin
      exp_s     = pick(exp_rr, last_cr);
      head_seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cycle(1'b0, 8'h00, 4'h0);
    cycle(1'b0, 8'h00, 4'h0);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b exp=0", OUT_VALID); end
    total++; if (Y_VALID !== 4'h0) begin bad++; $display("[TB] FAIL reset_y_valid got=%h exp=0", Y_VALID); end
    total++; if (IN_READY !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=1", IN_READY); end
    total++; if (TX_COUNT !== 16'd0) begin bad++; $display("[TB] FAIL reset_tx_count got=%0d exp=0", TX_COUNT); end
    total++; if (STALL_ERR !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall_err got=%b exp=0", STALL_ERR); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ed;
    logic [1:0] es;
    logic [3:0] ey;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'hA0 + 8'(i), 4'hF);
      if (i == 0) begin
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("[TB] FAIL b2b_latency_early got=%b exp=0", OUT_VALID); end
      end else begin
        ed = 8'hA0 + 8'(i - 1);
        es = 2'((i - 1) % 4);
        ey = 4'b0001 << es;
        total++; if (OUT_VALID !== 1'b1 || OUT_DATA !== ed || S !== es || Y_VALID !== ey) begin
          bad++; $display("[TB] FAIL b2b_word%0d got=v%b d%h s%0d y%h exp=v1 d%h s%0d y%h", i - 1, OUT_VALID, OUT_DATA, S, Y_VALID, ed, es, ey);
        end
      end
    end
    cycle(1'b0, 8'h00, 4'hF);
    total++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'hA4 || S !== 2'd0 || Y_VALID !== 4'h1) begin
      bad++; $display("[TB] FAIL b2b_word4 got=v%b d%h s%0d y%h exp=v1 dA4 s0 y1", OUT_VALID, OUT_DATA, S, Y_VALID);
    end
    cycle(1'b0, 8'h00, 4'hF);
    total++; if (TX_COUNT !== 16'd5 || OUT_VALID !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_count got=tx%0d v%b exp=tx5 v0", TX_COUNT, OUT_VALID);
    end
  endtask

  task automatic test_blocked_channel();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h30 + 8'(i), 4'hB);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'h00, 4'hB);
      total++; if (OUT_VALID !== exp_ov() || (exp_ov() && (OUT_DATA !== q[0].d || S !== exp_s)) || Y_VALID !== exp_y()) begin
        bad++; $display("[TB] FAIL blk_hold%0d got=v%b d%h s%0d y%h exp=v%b s%0d y%h", i, OUT_VALID, OUT_DATA, S, Y_VALID, exp_ov(), exp_s, exp_y());
      end
`ifndef DMUX_RR_SKIP_EN
      total++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h32 || S !== 2'd2 || Y_VALID !== 4'h4) begin
        bad++; $display("[TB] FAIL blk_strict%0d got=v%b d%h s%0d y%h exp=v1 d32 s2 y4", i, OUT_VALID, OUT_DATA, S, Y_VALID);
      end
`endif
    end
    cycle(1'b1, 8'h33, 4'hF);
    cycle(1'b0, 8'h00, 4'hF);
    total++; if (OUT_VALID !== exp_ov() || (exp_ov() && (OUT_DATA !== q[0].d || S !== exp_s))) begin
      bad++; $display("[TB] FAIL blk_next got=v%b d%h s%0d exp=v%b s%0d", OUT_VALID, OUT_DATA, S, exp_ov(), exp_s);
    end
`ifndef DMUX_RR_SKIP_EN
    total++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h33 || S !== 2'd3) begin
      bad++; $display("[TB] FAIL blk_next_strict got=v%b d%h s%0d exp=v1 d33 s3", OUT_VALID, OUT_DATA, S);
    end
`endif
    cycle(1'b0, 8'h00, 4'hF);
    total++; if (TX_COUNT !== 16'd4) begin bad++; $display("[TB] FAIL blk_count got=%0d exp=4", TX_COUNT); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h50 + 8'(i), 4'h0);
    total++; if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin
      bad++; $display("[TB] FAIL stall_full got=rdy%b v%b exp=rdy0 v1", IN_READY, OUT_VALID);
    end
    cycle(1'b1, 8'h53, 4'h0);
    for (int i = 0; i < 24; i++) begin
      total++; if (STALL_ERR !== exp_err) begin
        bad++; $display("[TB] FAIL stall_err cyc%0d got=%b exp=%b", i, STALL_ERR, exp_err);
      end
      cycle(1'b0, 8'h00, 4'h0);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 4'hF);
    total++; if (STALL_ERR !== 1'b1 || TX_COUNT !== 16'd3 || OUT_VALID !== 1'b0) begin
      bad++; $display("[TB] FAIL stall_drain got=err%b tx%0d v%b exp=err1 tx3 v0", STALL_ERR, TX_COUNT, OUT_VALID);
    end
  endtask

`ifdef DMUX_RR_SKIP_EN
  task automatic test_skip();
    do_reset();
    cycle(1'b1, 8'h61, 4'hA);
    cycle(1'b1, 8'h62, 4'hA);
    total++; if (OUT_VALID !== 1'b1 || S !== 2'd1) begin
      bad++; $display("[TB] FAIL skip_first got=v%b s%0d exp=v1 s1", OUT_VALID, S);
    end
    cycle(1'b0, 8'h00, 4'hA);
    total++; if (OUT_VALID !== 1'b1 || S !== 2'd3 || OUT_DATA !== 8'h62) begin
      bad++; $display("[TB] FAIL skip_second got=v%b s%0d d%h exp=v1 s3 d62", OUT_VALID, S, OUT_DATA);
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h70 + 8'(i), 4'h0);
    RST = 1'b1;
    cycle(1'b0, 8'h00, 4'hF);
    RST = 1'b0;
    total++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || TX_COUNT !== 16'd0) begin
      bad++; $display("[TB] FAIL rstmid_state got=v%b rdy%b tx%0d exp=v0 rdy1 tx0", OUT_VALID, IN_READY, TX_COUNT);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'h00, 4'hF);
      total++; if (OUT_VALID !== 1'b0 || TX_COUNT !== 16'd0) begin
        bad++; $display("[TB] FAIL rstmid_stale%0d got=v%b tx%0d exp=v0 tx0", i, OUT_VALID, TX_COUNT);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] cr;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      total++; if (OUT_VALID !== exp_ov()) begin bad++; $display("[TB] FAIL rnd_valid cyc%0d got=%b exp=%b", i, OUT_VALID, exp_ov()); end
      total++; if (IN_READY !== exp_in_ready()) begin bad++; $display("[TB] FAIL rnd_ready cyc%0d got=%b exp=%b", i, IN_READY, exp_in_ready()); end
      total++; if (TX_COUNT !== 16'(exp_tx)) begin bad++; $display("[TB] FAIL rnd_tx cyc%0d got=%0d exp=%0d", i, TX_COUNT, exp_tx); end
      total++; if (STALL_ERR !== exp_err) begin bad++; $display("[TB] FAIL rnd_err cyc%0d got=%b exp=%b", i, STALL_ERR, exp_err); end
      total++; if (Y_VALID !== exp_y()) begin bad++; $display("[TB] FAIL rnd_y cyc%0d got=%h exp=%h", i, Y_VALID, exp_y()); end
      if (exp_ov()) begin
        total++; if (OUT_DATA !== q[0].d || S !== exp_s) begin
          bad++; $display("[TB] FAIL rnd_word cyc%0d got=d%h s%0d exp=d%h s%0d", i, OUT_DATA, S, q[0].d, exp_s);
        end
      end
      case ((i / 250) % 3)
        0:       cr = 4'($urandom);
        1:       cr = 4'($urandom) & 4'($urandom) & 4'($urandom);
        default: cr = 4'($urandom) | 4'($urandom);
      endcase
      cycle($urandom_range(0, 3) != 0, 8'($urandom), cr);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_blocked_channel();
    test_stall();
`ifdef DMUX_RR_SKIP_EN
    test_skip();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
